// File: rtl/pmm_arb_pkg.sv
// Shared definitions for the PMM port arbiter: FSM states, parameter
// defaults, the abort fill byte and a saturating counter helper.
package pmm_arb_pkg;

  localparam int DEFAULT_NUM_PORTS = 4;
  localparam int DEFAULT_TIMEOUT   = 1024;

  localparam logic [7:0] ABORT_FILL_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // 16-bit event counter add that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pmm_rr_arbiter.sv
// Combinational round-robin picker: scans the request mask starting at
// the base index and returns the first requester as one-hot and index.
module pmm_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;
  logic          found;

  // First requester at or after base, wrapping modulo N.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(base) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pmm_port_arbiter.sv
// Packet-level arbiter that merges NUM_PORTS byte streams into the single
// PMM payload input. A port owns the PMM from its sop byte to its eop byte;
// a stalled owner is aborted after TIMEOUT idle cycles with a fill byte.
module pmm_port_arbiter
  import pmm_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*NUM_PORTS-1:0]     req_payload,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS-1:0]       req_sop,
  input  logic [NUM_PORTS-1:0]       req_eop,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic                       pmm_ready,
  output logic [7:0]                 pmm_payload,
  output logic                       pmm_payload_valid,
  output logic                       pmm_start_of_packet,
  output logic                       pmm_end_of_packet,
  output logic [$clog2(NUM_PORTS)-1:0] grant_port,
  output logic                       busy,
  output logic [15:0]                abort_count,
  output logic [15:0]                drop_count
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e     state;
  logic [IW-1:0]  last_grant;
  logic           first_beat;
  logic [TW-1:0]  idle_cnt;

  logic [NUM_PORTS-1:0] candidates;
  logic [NUM_PORTS-1:0] drop_mask;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [IW-1:0]        arb_idx;
  logic [IW-1:0]        rr_base;
  logic                 arb_any;
  logic                 sel_valid;
  logic                 sel_sop;
  logic                 sel_eop;
  logic [7:0]           sel_byte;
  logic                 accept;
  logic [3:0]           drop_num;

  // Packet heads compete for the PMM; headless bytes in IDLE are orphans.
  assign candidates = req_valid & req_sop;
  assign drop_mask  = (state == ST_IDLE && pmm_ready) ? (req_valid & ~req_sop) : '0;
  assign drop_num   = 4'($countones(drop_mask));

  assign rr_base = (last_grant == IW'(NUM_PORTS - 1)) ? '0 : last_grant + IW'(1);

  pmm_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .req       (candidates),
    .base      (rr_base),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign arb_any = |arb_grant;

  // The owning port's beat, selected by the registered grant.
  assign sel_valid = req_valid[grant_port];
  assign sel_sop   = req_sop[grant_port];
  assign sel_eop   = req_eop[grant_port];
  assign sel_byte  = req_payload[{grant_port, 3'b000} +: 8];
  assign accept    = (state == ST_XFER) && pmm_ready && sel_valid;

  assign busy = !rst && (state != ST_IDLE);

  // Ready: orphans are drained in IDLE, only the owner moves in XFER, nobody in ABORT.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: req_ready = drop_mask;
        ST_XFER: req_ready[grant_port] = pmm_ready;
        default: req_ready = '0;
      endcase
    end
  end

  // Arbitration FSM, registered PMM output stage and event counters.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state               <= ST_IDLE;
      last_grant          <= IW'(NUM_PORTS - 1);
      grant_port          <= '0;
      first_beat          <= 1'b0;
      idle_cnt            <= '0;
      pmm_payload         <= 8'h00;
      pmm_payload_valid   <= 1'b0;
      pmm_start_of_packet <= 1'b0;
      pmm_end_of_packet   <= 1'b0;
      abort_count         <= '0;
      drop_count          <= '0;
    end else begin
      pmm_payload_valid   <= 1'b0;
      pmm_start_of_packet <= 1'b0;
      pmm_end_of_packet   <= 1'b0;
      drop_count          <= sat_add16(drop_count, drop_num);

      case (state)
        ST_IDLE: begin
          if (pmm_ready && arb_any) begin
            grant_port <= arb_idx;
            first_beat <= 1'b1;
            idle_cnt   <= '0;
            state      <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (accept) begin
            pmm_payload         <= sel_byte;
            pmm_payload_valid   <= 1'b1;
            pmm_start_of_packet <= sel_sop & first_beat;
            pmm_end_of_packet   <= sel_eop;
            first_beat          <= 1'b0;
            idle_cnt            <= '0;
            if (sel_eop) begin
              last_grant <= grant_port;
              state      <= ST_IDLE;
            end
          end else if (pmm_ready && TIMEOUT != 0) begin
            idle_cnt <= idle_cnt + TW'(1);
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
              state <= ST_ABORT;
            end
          end
        end

        ST_ABORT: begin
          if (pmm_ready) begin
            pmm_payload       <= ABORT_FILL_BYTE;
            pmm_payload_valid <= 1'b1;
            pmm_end_of_packet <= 1'b1;
            abort_count       <= sat_add16(abort_count, 4'd1);
            last_grant        <= grant_port;
            state             <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmm_port_arbiter.sv
// Directed bench for pmm_port_arbiter: per-port byte sources driven from a
// small stream table, a log of every forwarded PMM byte, and one task per
// scenario comparing against hand-computed expectations.
module tb_pmm_port_arbiter;
  import pmm_arb_pkg::*;

  localparam int NP = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [8*NP-1:0] req_payload = '0;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_sop = '0;
  logic [NP-1:0]   req_eop = '0;
  logic [NP-1:0]   req_ready;
  logic            pmm_ready = 1'b1;
  logic [7:0]      pmm_payload;
  logic            pmm_payload_valid;
  logic            pmm_start_of_packet;
  logic            pmm_end_of_packet;
  logic [1:0]      grant_port;
  logic            busy;
  logic [15:0]     abort_count;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  pmm_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_payload         (req_payload),
    .req_valid           (req_valid),
    .req_sop             (req_sop),
    .req_eop             (req_eop),
    .req_ready           (req_ready),
    .pmm_ready           (pmm_ready),
    .pmm_payload         (pmm_payload),
    .pmm_payload_valid   (pmm_payload_valid),
    .pmm_start_of_packet (pmm_start_of_packet),
    .pmm_end_of_packet   (pmm_end_of_packet),
    .grant_port          (grant_port),
    .busy                (busy),
    .abort_count         (abort_count),
    .drop_count          (drop_count)
  );

  // Per-port byte streams; shold_at freezes a port when its pointer hits that index.
  logic [7:0] sbyte [NP][16];
  bit         ssop  [NP][16];
  bit         seop  [NP][16];
  int         slen  [NP];
  int         sptr  [NP];
  int         shold_at [NP];

  bit         rst_cfg = 1'b1;
  bit         rdy_cfg = 1'b1;
  logic [NP-1:0] hs = '0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // Log of forwarded PMM beats.
  logic [7:0] obyte [$];
  bit         osop  [$];
  bit         oeop  [$];
  int         ocyc  [$];
  logic [1:0] ogrant[$];

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (sptr[p] < slen[p] && sptr[p] != shold_at[p]) begin
        req_valid[p]           = 1'b1;
        req_payload[8*p +: 8]  = sbyte[p][sptr[p]];
        req_sop[p]             = ssop[p][sptr[p]];
        req_eop[p]             = seop[p][sptr[p]];
      end else begin
        req_valid[p]           = 1'b0;
        req_payload[8*p +: 8]  = 8'h00;
        req_sop[p]             = 1'b0;
        req_eop[p]             = 1'b0;
      end
    end
  endtask

  // One clock: retire last edge's handshakes, log outputs, drive next inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int p = 0; p < NP; p++) if (hs[p]) sptr[p]++;
    if (pmm_payload_valid) begin
      obyte.push_back(pmm_payload);
      osop.push_back(pmm_start_of_packet);
      oeop.push_back(pmm_end_of_packet);
      ocyc.push_back(cyc);
      ogrant.push_back(grant_port);
    end
    rst       = rst_cfg;
    pmm_ready = rdy_cfg;
    drive_inputs();
    #1;
    hs = req_valid & req_ready;
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      slen[p] = 0;
      sptr[p] = 0;
      shold_at[p] = -1;
    end
  endtask

  task automatic clear_log();
    obyte.delete(); osop.delete(); oeop.delete(); ocyc.delete(); ogrant.delete();
  endtask

  task automatic add_packet(input int p, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      sbyte[p][slen[p]] = base + 8'(k);
      ssop[p][slen[p]]  = (k == 0);
      seop[p][slen[p]]  = (k == n - 1);
      slen[p]++;
    end
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b = 0;
    while (obyte.size() < n && b < budget) begin
      step();
      b++;
    end
    if (obyte.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got %0d beats, expected %0d", name, obyte.size(), n);
    end
  endtask

  task automatic do_reset();
    clear_sources();
    rdy_cfg = 1'b1;
    rst_cfg = 1'b1;
    step();
    step();
    rst_cfg = 1'b0;
    step();
    clear_log();
  endtask

  task automatic test_reset();
    clear_sources();
    add_packet(0, 2, 8'h11);
    ssop[0][0] = 1'b0;
    rst_cfg = 1'b1;
    repeat (3) step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    checks++; if (pmm_payload !== 8'h00) begin errors++; $display("FAIL rst_payload: got %h expected 00", pmm_payload); end
    checks++; if (pmm_payload_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pmm_payload_valid); end
    checks++; if (pmm_start_of_packet !== 1'b0) begin errors++; $display("FAIL rst_sop: got %b expected 0", pmm_start_of_packet); end
    checks++; if (pmm_end_of_packet !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b expected 0", pmm_end_of_packet); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (grant_port !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_port); end
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL rst_abort_count: got %0d expected 0", abort_count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
    clear_sources();
    rst_cfg = 1'b0;
    step();
    clear_log();
  endtask

  task automatic test_two_ports();
    logic [7:0] eb [6];
    bit es [6];
    bit ee [6];
    int nsop;
    eb = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
    es = '{1, 0, 0, 1, 0, 0};
    ee = '{0, 0, 1, 0, 0, 1};
    do_reset();
    add_packet(0, 3, 8'hA0);
    add_packet(2, 3, 8'hC0);
    run_until(6, 40, "two_ports");
    nsop = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < obyte.size()) begin
        checks++;
        if (obyte[i] !== eb[i] || osop[i] !== es[i] || oeop[i] !== ee[i]) begin
          errors++;
          $display("FAIL two_ports_beat%0d: got %h sop=%b eop=%b expected %h sop=%b eop=%b",
                   i, obyte[i], osop[i], oeop[i], eb[i], es[i], ee[i]);
        end
        if (osop[i]) nsop++;
      end
    end
    if (obyte.size() >= 6) begin
      checks++; if (nsop != 2) begin errors++; $display("FAIL two_ports_sop_total: got %0d expected 2", nsop); end
      checks++; if (ogrant[0] !== 2'd0) begin errors++; $display("FAIL two_ports_grant_first: got %0d expected 0", ogrant[0]); end
      checks++; if (ogrant[3] !== 2'd2) begin errors++; $display("FAIL two_ports_grant_second: got %0d expected 2", ogrant[3]); end
      checks++; if (ocyc[1] - ocyc[0] != 1) begin errors++; $display("FAIL two_ports_back_to_back: got gap %0d expected 1", ocyc[1] - ocyc[0]); end
      checks++; if (ocyc[3] - ocyc[2] != 2) begin errors++; $display("FAIL two_ports_bubble: got gap %0d expected 2", ocyc[3] - ocyc[2]); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_b;
    do_reset();
    for (int p = 0; p < NP; p++) begin
      add_packet(p, 2, 8'(p * 16));
      add_packet(p, 2, 8'(p * 16 + 8));
    end
    run_until(16, 100, "round_robin");
    for (int k = 0; k < 8; k++) begin
      exp_g = 2'(k % 4);
      exp_b = 8'((k % 4) * 16 + ((k >= 4) ? 8 : 0));
      if (2 * k < obyte.size()) begin
        checks++;
        if (ogrant[2*k] !== exp_g || osop[2*k] !== 1'b1 || obyte[2*k] !== exp_b) begin
          errors++;
          $display("FAIL rr_packet%0d: got port %0d byte %h sop=%b expected port %0d byte %h sop=1",
                   k, ogrant[2*k], obyte[2*k], osop[2*k], exp_g, exp_b);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    add_packet(1, 5, 8'hB0);
    shold_at[1] = 2;
    run_until(2, 20, "timeout_head");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_stall: got %b expected 1", busy); end
    t0 = (obyte.size() >= 2) ? ocyc[1] : cyc;
    run_until(3, 30, "timeout_abort");
    if (obyte.size() >= 3) begin
      checks++; if (ocyc[2] - t0 != 9) begin errors++; $display("FAIL timeout_latency: got gap %0d expected 9", ocyc[2] - t0); end
      checks++;
      if (obyte[2] !== 8'h00 || oeop[2] !== 1'b1 || osop[2] !== 1'b0) begin
        errors++;
        $display("FAIL timeout_fill: got %h sop=%b eop=%b expected 00 sop=0 eop=1", obyte[2], osop[2], oeop[2]);
      end
    end
    checks++; if (abort_count !== 16'd1) begin errors++; $display("FAIL timeout_abort_count: got %0d expected 1", abort_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after: got %b expected 0", busy); end
    shold_at[1] = -1;
    repeat (6) step();
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL timeout_drop_count: got %0d expected 3", drop_count); end
    checks++; if (sptr[1] != 5) begin errors++; $display("FAIL timeout_drained: got %0d bytes taken expected 5", sptr[1]); end
    checks++; if (obyte.size() != 3) begin errors++; $display("FAIL timeout_no_forward: got %0d beats expected 3", obyte.size()); end
  endtask

  task automatic test_backpressure();
    int n0;
    do_reset();
    add_packet(0, 6, 8'h50);
    run_until(2, 20, "bp_head");
    rdy_cfg = 1'b0;
    step();
    n0 = obyte.size();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready%0d: got %b expected 0000", i, req_ready); end
    end
    shold_at[0] = sptr[0];
    repeat (5) step();
    checks++; if (obyte.size() != n0) begin errors++; $display("FAIL bp_no_pulse: got %0d beats expected %0d", obyte.size(), n0); end
    rdy_cfg = 1'b1;
    repeat (6) step();
    checks++; if (busy !== 1'b1 || abort_count !== 16'd0) begin errors++; $display("FAIL bp_timer_frozen: got busy=%b aborts=%0d expected busy=1 aborts=0", busy, abort_count); end
    shold_at[0] = -1;
    run_until(6, 30, "bp_resume");
    for (int i = 0; i < 6; i++) begin
      if (i < obyte.size()) begin
        checks++;
        if (obyte[i] !== 8'(8'h50 + i) || oeop[i] !== (i == 5)) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h eop=%b expected %h eop=%0d", i, obyte[i], oeop[i], 8'(8'h50 + i), (i == 5));
        end
      end
    end
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL bp_abort_count: got %0d expected 0", abort_count); end
  endtask

  task automatic test_single_then_reset();
    int neop;
    do_reset();
    add_packet(3, 1, 8'hE1);
    add_packet(3, 4, 8'hF0);
    run_until(3, 30, "single_head");
    if (obyte.size() >= 1) begin
      checks++;
      if (obyte[0] !== 8'hE1 || osop[0] !== 1'b1 || oeop[0] !== 1'b1 || ogrant[0] !== 2'd3) begin
        errors++;
        $display("FAIL single_byte: got %h sop=%b eop=%b port %0d expected e1 sop=1 eop=1 port 3",
                 obyte[0], osop[0], oeop[0], ogrant[0]);
      end
    end
    rst_cfg = 1'b1;
    step();
    step();
    checks++; if (pmm_payload !== 8'h00 || pmm_payload_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_payload: got %h valid=%b expected 00 valid=0", pmm_payload, pmm_payload_valid); end
    checks++; if (pmm_start_of_packet !== 1'b0 || pmm_end_of_packet !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got sop=%b eop=%b expected 0 0", pmm_start_of_packet, pmm_end_of_packet); end
    checks++; if (busy !== 1'b0 || grant_port !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got busy=%b grant=%0d expected 0 0", busy, grant_port); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_req_ready: got %b expected 0000", req_ready); end
    checks++; if (abort_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL mid_rst_counters: got %0d %0d expected 0 0", abort_count, drop_count); end
    neop = 0;
    foreach (oeop[i]) if (oeop[i]) neop++;
    checks++; if (neop != 1) begin errors++; $display("FAIL mid_rst_no_synth_eop: got %0d eops expected 1", neop); end
    add_packet(2, 2, 8'h20);
    add_packet(1, 2, 8'h10);
    rst_cfg = 1'b0;
    clear_log();
    run_until(2, 20, "post_rst");
    if (obyte.size() >= 1) begin
      checks++;
      if (ogrant[0] !== 2'd1 || obyte[0] !== 8'h10 || osop[0] !== 1'b1) begin
        errors++;
        $display("FAIL post_rst_grant: got port %0d byte %h sop=%b expected port 1 byte 10 sop=1", ogrant[0], obyte[0], osop[0]);
      end
    end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL post_rst_drop: got %0d expected 1", drop_count); end
  endtask

  initial begin
    clear_sources();
    test_reset();
    test_two_ports();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_single_then_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pmm_port_arbiter.md
PMM_PORT_ARBITER -- requirements
Module: pmm_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of payload requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles before a granted packet is aborted; 0 disables abort.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port req_payload  in  8*NUM_PORTS  byte per port; port p uses bits [8p+7:8p].
REQ-006 SHALL have port req_valid  in  NUM_PORTS  per-port byte valid.
REQ-007 SHALL have port req_sop  in  NUM_PORTS  per-port start-of-packet, qualified by req_valid.
REQ-008 SHALL have port req_eop  in  NUM_PORTS  per-port end-of-packet, qualified by req_valid.
REQ-009 SHALL have port req_ready  out  NUM_PORTS  per-port accept; a beat transfers when valid and ready are both high.
REQ-010 SHALL have port pmm_ready  in  1  PMM can accept a byte this cycle.
REQ-011 SHALL have port pmm_payload  out  8  byte to the PMM payload_in.
REQ-012 SHALL have port pmm_payload_valid  out  1  one-cycle pulse per forwarded byte.
REQ-013 SHALL have port pmm_start_of_packet  out  1  qualified by pmm_payload_valid.
REQ-014 SHALL have port pmm_end_of_packet  out  1  qualified by pmm_payload_valid.
REQ-015 SHALL have port grant_port  out  clog2(NUM_PORTS)  index of the current or last granted port.
REQ-016 SHALL have port busy  out  1  high while a packet owns the PMM.
REQ-017 SHALL have port abort_count  out  16  number of timeout aborts, saturating at 0xFFFF.
REQ-018 SHALL have port drop_count  out  16  number of discarded orphan bytes, saturating at 0xFFFF.

Function
REQ-019 SHALL implement states IDLE, XFER and ABORT.
REQ-020 IDLE: a candidate is a port with req_valid=1 and req_sop=1; with any candidate present, SHALL grant by round-robin starting at last_grant+1 modulo NUM_PORTS, and SHALL enter XFER the next cycle.
REQ-021 IDLE: SHALL assert req_ready for every port presenting req_valid=1 and req_sop=0, discard those bytes, and add one to drop_count per discarded byte.
REQ-022 XFER: req_ready[grant] SHALL equal pmm_ready; all other req_ready bits SHALL be 0.
REQ-023 Each accepted beat SHALL appear on pmm_* registered, exactly 1 cycle later; pmm_payload_valid SHALL be 0 in every other cycle.
REQ-024 pmm_start_of_packet SHALL be 1 only on the first byte of a granted packet; a req_sop on a later byte SHALL be forwarded with sop masked to 0.
REQ-025 An accepted beat with req_eop=1 SHALL forward eop=1, set last_grant to the granted port, and return to IDLE; this gives one bubble cycle between packets.
REQ-026 A beat carrying both sop and eop SHALL be forwarded as a one-byte packet.
REQ-027 Timeout counter: SHALL count XFER cycles with pmm_ready=1 and req_valid[grant]=0, clear on each accepted beat, and clear on XFER entry.
REQ-028 When TIMEOUT is nonzero and the counter reaches TIMEOUT, SHALL enter ABORT.
REQ-029 ABORT: req_ready SHALL be all 0; on the first cycle with pmm_ready=1, SHALL emit a synthetic byte 0x00 with eop=1, increment abort_count, set last_grant, and return to IDLE.
REQ-030 After an abort, leftover bytes from the aborted port arrive without sop and SHALL be discarded by REQ-021.
REQ-031 While pmm_ready=0, no beat SHALL be accepted or emitted, and state SHALL be held.
REQ-032 busy SHALL be 1 in XFER and ABORT, and 0 in IDLE.
REQ-033 grant_port SHALL update on grant and hold its value in IDLE.

Reset
REQ-034 On rst=1 SHALL force state IDLE; req_ready=0; pmm_payload=0x00; pmm_payload_valid, pmm_start_of_packet, pmm_end_of_packet and busy =0; grant_port=0; counters=0; last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-035 Reset in mid-packet SHALL NOT emit a synthetic eop; the next byte is accepted only after rst=0.

Structure
REQ-036 Shared package pmm_arb_pkg SHALL hold the state enum, the NUM_PORTS and TIMEOUT defaults, and ABORT_FILL_BYTE=8'h00.
REQ-037 The round-robin picker SHALL be a sub-module pmm_rr_arbiter, combinational, taking request mask and base index and returning a one-hot grant plus index.

Verification
REQ-038 Ports 0 and 2 each present a 3-byte packet in the same cycle after reset -> port 0 is forwarded first, one bubble, then port 2; pmm_start_of_packet asserts on 2 bytes total; grant_port goes 0 then 2.
REQ-039 All 4 ports continuously request -> grant order is 0,1,2,3,0; no port is granted twice before the others are served.
REQ-040 TIMEOUT=8, port 1 stalls after byte 2 of a 5-byte packet -> 8 idle cycles, synthetic 0x00 with eop, abort_count=1; the remaining 3 bytes are discarded, drop_count=3.
REQ-041 pmm_ready held 0 for 5 cycles mid-packet -> req_ready=0, no pmm_payload_valid pulses, the timeout counter does not advance, and transfer resumes without loss.
REQ-042 Single-byte packet (sop=eop=1) on port 3, then rst asserted mid-way through a following 4-byte packet -> 1 byte with sop=eop=1 is emitted; after reset all outputs are 0 and the next grant goes to the lowest requesting port.
